systolic_job_sched: RTL

Job controller and two-port arbiter for the 2x2 systolic multiply array. Accepts complete 2x2 A/B operand sets from two requesters, grants the array round-robin, and drives the array's operand and `in_valid` inputs for the job. It then captures the array's C result on `out_valid` and returns it to the owning requester over a valid/ready response channel. It sits between the array and the front-end DMA/command queues.

---
 rtl/systolic_job_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/systolic_job_sched.sv
// rtl/systolic_job_sched.sv - job controller and round-robin arbiter for the 2x2 systolic multiply array
// Optional RUN-state watchdog is compiled in when SA_TIMEOUT_EN is defined.
module systolic_job_sched #(
    parameter int DATA_WIDTH     = 4,
    parameter int ACC_WIDTH      = 9,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [4*DATA_WIDTH-1:0] req0_a,
    input  logic [4*DATA_WIDTH-1:0] req0_b,
    input  logic [4*DATA_WIDTH-1:0] req1_a,
    input  logic [4*DATA_WIDTH-1:0] req1_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [4*ACC_WIDTH-1:0]  rsp_c,
    output logic                    rsp_err,
    output logic                    sa_in_valid,
    output logic [4*DATA_WIDTH-1:0] sa_a,
    output logic [4*DATA_WIDTH-1:0] sa_b,
    input  logic                    sa_out_valid,
    input  logic [4*ACC_WIDTH-1:0]  sa_c,
    output logic                    busy
);

    // One counter serves both the GAP hold-off and the RUN watchdog.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    rsp_id_q, rsp_id_d;
    logic [4*DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [4*DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [4*ACC_WIDTH-1:0]  rsp_c_q, rsp_c_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    grant_valid;
    logic                    grant_id;
    logic                    run_expired;

`ifdef SA_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    assign run_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = rsp_err_q;
`else
    assign run_expired = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Requester after last_grant wins a tie; otherwise the sole requester wins.
    always_comb begin
        grant_valid = |req_valid;
        if (&req_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_c_d      = rsp_c_q;
        cnt_d        = cnt_q;
        req_ready    = 2'b00;
`ifdef SA_TIMEOUT_EN
        rsp_err_d    = rsp_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    op_a_d       = grant_id ? req1_a : req0_a;
                    op_b_d       = grant_id ? req1_b : req0_b;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the expiry cycle still wins.
                if (sa_out_valid) begin
                    rsp_c_d = sa_c;
                    state_d = S_RESP;
`ifdef SA_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end else if (run_expired) begin
                    rsp_c_d = '0;
                    state_d = S_RESP;
`ifdef SA_TIMEOUT_EN
                    rsp_err_d = 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_c_q      <= '0;
            cnt_q        <= '0;
`ifdef SA_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_c_q      <= rsp_c_d;
            cnt_q        <= cnt_d;
`ifdef SA_TIMEOUT_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign sa_in_valid = (state_q == S_RUN);
    assign rsp_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign sa_a        = op_a_q;
    assign sa_b        = op_b_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_c       = rsp_c_q;

endmodule
